// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: shared register offsets and stride for the GPIO bank register map.
package gpio_bank_pkg;
   localparam int OFS_OUT    = 0;
   localparam int OFS_IN     = 1;
   localparam int OFS_IEN    = 2;
   localparam int OFS_ISTAT  = 3;
   localparam int REG_STRIDE = 4;
   function automatic int reg_idx(input int port, input int ofs);
      return port * REG_STRIDE + ofs;
   endfunction
endpackage

// File: rtl/gpio_port.sv
// gpio_port: one 8-bit port with OUT/IEN/ISTAT registers, input synchroniser and pulse counter.
module gpio_port #(
   parameter logic [7:0]  GPO_DFT_VAL = 8'h00,
   parameter logic [7:0]  PULSE_MASK  = 8'h00,
   parameter logic [15:0] PULSE_CYC   = 16'd1000
) (
   input  logic       SYSCLK,
   input  logic       RESET_N,
   input  logic       out_we,
   input  logic       ien_we,
   input  logic       istat_we,
   input  logic [7:0] din,
   input  logic [7:0] gpi,
   output logic [7:0] out_q,
   output logic [7:0] in_q,
   output logic [7:0] ien_q,
   output logic [7:0] istat_q
);
   logic [7:0]  sync1, sync2, sync3, out_d, istat_d;
   logic [15:0] cnt, cnt_d;
   logic        load, expire;
   // Any OUT write while running retriggers; a write also overrides a coincident expiry.
   always_comb begin
      load    = out_we & ((|(din & PULSE_MASK)) | (cnt != '0));
      expire  = (cnt == 16'd1) & ~out_we;
      cnt_d   = load ? PULSE_CYC : (cnt != '0) ? cnt - 16'd1 : cnt;
      out_d   = out_we ? din : expire ? (out_q & ~PULSE_MASK) : out_q;
      istat_d = (istat_q & ~(istat_we ? din : 8'h00)) | (sync2 & ~sync3);
   end
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1   <= '0;
         sync2   <= '0;
         sync3   <= '0;
         cnt     <= '0;
         out_q   <= GPO_DFT_VAL;
         ien_q   <= '0;
         istat_q <= '0;
      end else begin
         sync1   <= gpi;
         sync2   <= sync1;
         sync3   <= sync2;
         cnt     <= cnt_d;
         out_q   <= out_d;
         ien_q   <= ien_we ? din : ien_q;
         istat_q <= istat_d;
      end
   end
   assign in_q = sync2;
endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: NUM_PORTS GPIO ports behind a one-hot register select, with registered read data and IRQ.
module gpio_bank
   import gpio_bank_pkg::*;
#(
   parameter int                     NUM_PORTS   = 4,
   parameter logic [7:0]             GPO_DFT_VAL = 8'h00,
   parameter logic [NUM_PORTS*8-1:0] PULSE_MASK  = {NUM_PORTS*8{1'b0}},
   parameter logic [15:0]            PULSE_CYC   = 16'd1000
) (
   input  logic                   SYSCLK,
   input  logic                   RESET_N,
   input  logic                   PORT_CS,
   input  logic [4*NUM_PORTS-1:0] OFFSET_SEL,
   input  logic                   RD_WR,
   input  logic [7:0]             DIN,
   output logic [7:0]             DOUT,
   input  logic [8*NUM_PORTS-1:0] GPI,
   output logic [8*NUM_PORTS-1:0] GPO,
   output logic                   IRQ
);
   logic [7:0]           out_q [NUM_PORTS];
   logic [7:0]           in_q [NUM_PORTS];
   logic [7:0]           ien_q [NUM_PORTS];
   logic [7:0]           istat_q [NUM_PORTS];
   logic [NUM_PORTS-1:0] irq_p;
   logic [7:0]           rdata;
   logic                 wr, rd;
   assign wr = PORT_CS & ~RD_WR;
   assign rd = PORT_CS & RD_WR;
   genvar p;
   generate
      for (p = 0; p < NUM_PORTS; p++) begin : g_port
         gpio_port #(
            .GPO_DFT_VAL (GPO_DFT_VAL),
            .PULSE_MASK  (PULSE_MASK[8*p +: 8]),
            .PULSE_CYC   (PULSE_CYC)
         ) u_port (
            .SYSCLK   (SYSCLK),
            .RESET_N  (RESET_N),
            .out_we   (wr & OFFSET_SEL[reg_idx(p, OFS_OUT)]),
            .ien_we   (wr & OFFSET_SEL[reg_idx(p, OFS_IEN)]),
            .istat_we (wr & OFFSET_SEL[reg_idx(p, OFS_ISTAT)]),
            .din      (DIN),
            .gpi      (GPI[8*p +: 8]),
            .out_q    (out_q[p]),
            .in_q     (in_q[p]),
            .ien_q    (ien_q[p]),
            .istat_q  (istat_q[p])
         );
         assign GPO[8*p +: 8] = out_q[p];
         assign irq_p[p]      = |(istat_q[p] & ien_q[p]);
      end
   endgenerate
   // Multi-hot selects OR together; an empty select reads zero.
   always_comb begin
      rdata = 8'h00;
      for (int i = 0; i < NUM_PORTS; i++) begin
         rdata = rdata
               | (OFFSET_SEL[reg_idx(i, OFS_OUT)]   ? out_q[i]   : 8'h00)
               | (OFFSET_SEL[reg_idx(i, OFS_IN)]    ? in_q[i]    : 8'h00)
               | (OFFSET_SEL[reg_idx(i, OFS_IEN)]   ? ien_q[i]   : 8'h00)
               | (OFFSET_SEL[reg_idx(i, OFS_ISTAT)] ? istat_q[i] : 8'h00);
      end
   end
   always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) DOUT <= 8'h00;
      else          DOUT <= rd ? rdata : DOUT;
   end
   assign IRQ = |irq_p;
endmodule
